// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_pkg
//  Description : Shared constants for the GF(2^233) signature streaming path.
//                Field widths, packed-buffer width, control state encoding and
//                a helper that packs an (r, s) pair into the 512-bit buffer.
//  Revision    : 1.0  initial release
// ============================================================================
package ecc_pkg;

  localparam int ECC_M   = 233;            // field element width
  localparam int ECC_PAD = 256;            // element width padded to a word
  localparam int ECC_BUF = 2 * ECC_PAD;    // packed (r, s) buffer width

  // Control state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SIGN = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  // {pad, a, pad, b}: a occupies the upper 256-bit field, b the lower one.
  function automatic logic [ECC_BUF-1:0] ecc_pack(input logic [ECC_M-1:0] a,
                                                  input logic [ECC_M-1:0] b);
    return {{(ECC_PAD-ECC_M){1'b0}}, a, {(ECC_PAD-ECC_M){1'b0}}, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_piso.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_piso
//  Description : 512-bit parallel-load, W-bit-per-word shift-out register with
//                valid/ready handshake, word counter and last-word flag.
//                Words leave MSB-first.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                load, load_data - parallel load (starts a new stream)
//                ready           - consumer accepts the current word
//                data, valid     - current word and its qualifier
//                last            - current word is the final one
//                xfer_last       - final word transferred this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module ecc_piso
  import ecc_pkg::*;
#(
  parameter int W = 32                     // 8, 16, 32 or 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [ECC_BUF-1:0] load_data,
  input  logic               ready,
  output logic [W-1:0]       data,
  output logic               valid,
  output logic               last,
  output logic               xfer_last
);

  localparam int NW = ECC_BUF / W;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NW - 1);

  logic [ECC_BUF-1:0] buf_q, buf_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               xfer;
  logic [CW-1:0]      cnt_inc;

  assign xfer    = valid_q & ready;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      buf_d   = load_data;
      cnt_d   = '0;
      valid_d = 1'b1;
      last_d  = (CNT_LAST == '0);
    end else if (xfer) begin
      buf_d = buf_q << W;
      cnt_d = cnt_inc;
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        // The word becoming current next is the final one.
        last_d = (cnt_inc == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign data      = buf_q[ECC_BUF-1 -: W];
  assign valid     = valid_q;
  assign last      = last_q;
  assign xfer_last = xfer & last_q;

endmodule
`default_nettype wire

// File: rtl/ecc_sig_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : ecc_sig_streamer
//  Description : Control and output stage for the GF(2^233) ECC signing core.
//                Enables the core for one run, captures (r, s) on ready,
//                streams the pair as 512/W words, then re-arms. A watchdog
//                aborts the run if the core never reports ready.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start               - request a signing run (IDLE only)
//                busy                - not idle
//                sign_en             - core enable (low holds core in reset)
//                sig_rdy, r, s       - core ready and signature
//                out_data/valid/ready/last - word stream
//                done                - pulse after final word accepted
//                err                 - pulse on watchdog abort
//  Revision    : 1.0  initial release
// ============================================================================
module ecc_sig_streamer
  import ecc_pkg::*;
#(
  parameter int W         = 32,
  parameter int TO_CYCLES = 1048576,
  parameter int TO_W      = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             sign_en,
  input  logic             sig_rdy,
  input  logic [ECC_M-1:0] r,
  input  logic [ECC_M-1:0] s,
  output logic [W-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             done,
  output logic             err
);

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic            sign_en_q, sign_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            load;
  logic            xfer_last;

  always_comb begin
    state_d   = state_q;
    sign_en_d = sign_en_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wd_d      = wd_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SIGN;
          sign_en_d = 1'b1;
          wd_d      = '0;
        end
      end
      ST_SIGN: begin
        if (sig_rdy) begin
          // Dropping sign_en here keeps the core in reset for the whole
          // stream, so its ready is gone before the next run can begin.
          load      = 1'b1;
          sign_en_d = 1'b0;
          state_d   = ST_SEND;
        end else if (wd_q == WD_LAST) begin
          sign_en_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        sign_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sign_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      sign_en_q <= sign_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wd_q      <= wd_d;
    end
  end

  ecc_piso #(
    .W (W)
  ) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (ecc_pack(r, s)),
    .ready     (out_ready),
    .data      (out_data),
    .valid     (out_valid),
    .last      (out_last),
    .xfer_last (xfer_last)
  );

  assign busy    = (state_q != ST_IDLE);
  assign sign_en = sign_en_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire
